// File: rtl/reg_select_decoder.sv
// reg_select_decoder: registered 5-to-32 one-hot enable decoder with timed strobe, sweep mode and done handshake
module reg_select_decoder #(
  parameter int STROBE_CYCLES = 1,
  parameter bit R0_PROTECT    = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  sel,
  input  logic        req,
  input  logic        sweep,
  output logic [31:0] en,
  output logic [4:0]  sel_q,
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] SWEEP  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  localparam logic [4:0] FIRST  = R0_PROTECT ? 5'd1 : 5'd0;
  localparam logic [4:0] HOLD   = 5'(STROBE_CYCLES - 1);
  logic [1:0] state;
  logic [4:0] cnt;
  logic       r0_hit;
  assign r0_hit = R0_PROTECT && sel == 5'd0;
  // cnt is the hold countdown in STROBE and the walking index in SWEEP
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      sel_q <= '0;
      en    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sweep) begin
            state <= SWEEP;
            cnt   <= FIRST;
            en    <= 32'd1 << FIRST;
            busy  <= 1'b1;
          end else if (req) begin
            state <= STROBE;
            cnt   <= HOLD;
            sel_q <= sel;
            en    <= r0_hit ? '0 : 32'd1 << sel;
            busy  <= 1'b1;
          end
        end
        STROBE: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          else begin
            state <= DONE;
            en    <= '0;
            done  <= 1'b1;
          end
        end
        SWEEP: begin
          if (cnt != 5'd31) begin
            cnt <= cnt + 5'd1;
            en  <= 32'd1 << (cnt + 5'd1);
          end else begin
            state <= DONE;
            cnt   <= '0;
            en    <= '0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_select_decoder.sv
// tb_reg_select_decoder: three parameterisations share one stimulus stream; each is checked against a timeline model
module tb_reg_select_decoder;
  logic clk = 1'b0;
  logic clr, req, sweep;
  logic [4:0] sel;
  logic [31:0] en [3];
  logic [4:0] sq_o [3];
  logic busy [3];
  logic done [3];
  always #5 clk = ~clk;

  reg_select_decoder #(.STROBE_CYCLES(1), .R0_PROTECT(1'b0)) u0 (
    .clk(clk), .clr(clr), .sel(sel), .req(req), .sweep(sweep),
    .en(en[0]), .sel_q(sq_o[0]), .busy(busy[0]), .done(done[0]));
  reg_select_decoder #(.STROBE_CYCLES(3), .R0_PROTECT(1'b0)) u1 (
    .clk(clk), .clr(clr), .sel(sel), .req(req), .sweep(sweep),
    .en(en[1]), .sel_q(sq_o[1]), .busy(busy[1]), .done(done[1]));
  reg_select_decoder #(.STROBE_CYCLES(2), .R0_PROTECT(1'b1)) u2 (
    .clk(clk), .clr(clr), .sel(sel), .req(req), .sweep(sweep),
    .en(en[2]), .sel_q(sq_o[2]), .busy(busy[2]), .done(done[2]));

  typedef struct packed {
    logic [31:0] en;
    logic [4:0]  sq;
    logic        busy;
    logic        done;
  } out_t;

  typedef struct {
    logic        clr, req, sweep;
    logic [4:0]  sel;
    logic [31:0] en;
    logic [4:0]  sq;
    logic        busy, done;
  } vec_t;

  int passed = 0;
  int total = 0;
  int n = 0;
  int t0 [3];
  int kind [3];
  logic [4:0] msq [3];

  function automatic int sc(int i);
    return i == 0 ? 1 : i == 1 ? 3 : 2;
  endfunction

  function automatic int r0(int i);
    return i == 2 ? 1 : 0;
  endfunction

  // Expected outputs during cycle m, from the start cycle and kind of the last accepted operation
  function automatic out_t model(int i, int m);
    out_t o;
    int d, last;
    d = m - t0[i];
    o = '0;
    o.sq = msq[i];
    if (kind[i] == 1) begin
      if (d >= 1 && d <= sc(i)) begin
        o.busy = 1'b1;
        o.en = (r0(i) == 1 && msq[i] == 5'd0) ? 32'd0 : 32'd1 << msq[i];
      end else if (d == sc(i) + 1) begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
    end else if (kind[i] == 2) begin
      last = 32 - r0(i);
      if (d >= 1 && d <= last) begin
        o.busy = 1'b1;
        o.en = 32'd1 << (d - 1 + r0(i));
      end else if (d == last + 1) begin
        o.busy = 1'b1;
        o.done = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic chk(string name, int i, logic [38:0] act, logic [38:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s u%0d cycle %0d: got %h expected %h", name, i, n, act, exp);
  endtask

  task automatic step();
    out_t act;
    logic acc [3];
    for (int i = 0; i < 3; i++) acc[i] = !model(i, n).busy && (req || sweep);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        kind[i] = 0;
        msq[i] = 5'd0;
      end else if (acc[i]) begin
        t0[i] = n;
        kind[i] = sweep ? 2 : 1;
        if (!sweep) msq[i] = sel;
      end
    end
    n++;
    #1;
    for (int i = 0; i < 3; i++) begin
      act = {en[i], sq_o[i], busy[i], done[i]};
      chk("outputs", i, 39'(act), 39'(model(i, n)));
      chk("onehot", i, 39'($countones(en[i]) <= 1), 39'd1);
    end
  endtask

  task automatic drive(logic c, logic r, logic s, logic [4:0] sl);
    @(negedge clk);
    clr = c;
    req = r;
    sweep = s;
    sel = sl;
    step();
  endtask

  task automatic idle(int k);
    for (int j = 0; j < k; j++) drive(1'b0, 1'b0, 1'b0, 5'($urandom));
  endtask

  vec_t tbl [10];

  initial begin
    out_t a;
    for (int i = 0; i < 3; i++) begin
      t0[i] = 0;
      kind[i] = 0;
      msq[i] = 5'd0;
    end
    clr = 1'b1; req = 1'b0; sweep = 1'b0; sel = 5'd0;
    // Hand-derived expectations for u0 (STROBE_CYCLES=1, no R0 protection)
    tbl[0] = '{1, 0, 0, 5'd0,  32'h0,        5'd0,  0, 0};
    tbl[1] = '{1, 1, 1, 5'd9,  32'h0,        5'd0,  0, 0};
    tbl[2] = '{0, 1, 0, 5'd10, 32'h00000400, 5'd10, 1, 0};
    tbl[3] = '{0, 0, 0, 5'd7,  32'h0,        5'd10, 1, 1};
    tbl[4] = '{0, 0, 0, 5'd7,  32'h0,        5'd10, 0, 0};
    tbl[5] = '{0, 1, 0, 5'd31, 32'h80000000, 5'd31, 1, 0};
    tbl[6] = '{0, 1, 0, 5'd3,  32'h0,        5'd31, 1, 1};
    tbl[7] = '{0, 0, 0, 5'd3,  32'h0,        5'd31, 0, 0};
    tbl[8] = '{0, 1, 1, 5'd4,  32'h00000001, 5'd31, 1, 0};
    tbl[9] = '{0, 0, 0, 5'd4,  32'h00000002, 5'd31, 1, 0};
    for (int v = 0; v < 10; v++) begin
      drive(tbl[v].clr, tbl[v].req, tbl[v].sweep, tbl[v].sel);
      a = {en[0], sq_o[0], busy[0], done[0]};
      chk("table", 0, 39'(a), 39'({tbl[v].en, tbl[v].sq, tbl[v].busy, tbl[v].done}));
    end
    idle(40);
    // STROBE_CYCLES=3: req sel=31, then req sel=3 while busy
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 1'b1, 1'b0, 5'd31);
    drive(1'b0, 1'b1, 1'b0, 5'd3);
    chk("hold31", 1, 39'(en[1]), 39'(32'h80000000));
    drive(1'b0, 1'b1, 1'b0, 5'd3);
    drive(1'b0, 1'b0, 1'b0, 5'd3);
    chk("done31", 1, 39'({done[1], sq_o[1]}), 39'({1'b1, 5'd31}));
    idle(3);
    // sweep and req together, then R0-protected index 0
    drive(1'b0, 1'b1, 1'b1, 5'd12);
    idle(34);
    drive(1'b0, 1'b1, 1'b0, 5'd0);
    idle(4);
    drive(1'b0, 1'b0, 1'b1, 5'd0);
    idle(34);
    // clr during the 17th sweep cycle, then a req one cycle later
    drive(1'b0, 1'b0, 1'b1, 5'd0);
    idle(16);
    drive(1'b1, 1'b0, 1'b0, 5'd0);
    chk("sweep_abort", 2, 39'({en[2], busy[2], done[2]}), 39'd0);
    drive(1'b0, 1'b1, 1'b0, 5'd6);
    idle(5);
    // back-to-back at the minimum period of u1, then of u0
    for (int s = 0; s < 32; s++) begin
      drive(1'b0, 1'b1, 1'b0, 5'(s));
      idle(4);
    end
    for (int s = 0; s < 32; s++) begin
      drive(1'b0, 1'b1, 1'b0, 5'(31 - s));
      idle(2);
    end
    idle(6);
    for (int j = 0; j < 3000; j++)
      drive($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(15) == 0, 5'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reg_select_decoder.md
# reg_select_decoder

Registered 5-to-32 one-hot decoder with a request/done handshake. It drives the register-file enable lines of the datapath. It is the counterpart of the 32-to-5 select encoder: the encoder turns a one-hot enable vector into an index, and this block turns an index back into a timed one-hot enable strobe. It also provides a sweep mode that pulses every enable line in turn, used for register-file initialisation.

## Interface
Parameters:
- STROBE_CYCLES, 1, number of consecutive cycles a single-select enable is held high; legal range 1..16.
- R0_PROTECT, 0, when 1, enable bit 0 is never asserted; index 0 requests complete without a strobe, and sweep skips bit 0.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset, highest priority.
- sel  input  5  register index, sampled when a request is accepted.
- req  input  1  single-select request, sampled only while busy=0.
- sweep  input  1  sweep request, sampled only while busy=0; has priority over req in the same cycle.
- en  output  32  registered one-hot enable vector; all-zero when not strobing.
- sel_q  output  5  latched index of the current or last single-select operation.
- busy  output  1  high from the cycle after acceptance until the operation ends, including the DONE cycle.
- done  output  1  single-cycle completion pulse.

## Operation
- States: IDLE, STROBE, SWEEP, DONE. All outputs are registered.
- IDLE: en=0, busy=0, done=0.
  - sweep=1: go to SWEEP with counter=0, or counter=1 if R0_PROTECT.
  - else req=1: latch sel into sel_q, load the hold counter with STROBE_CYCLES-1, go to STROBE.
- STROBE: en = 1<<sel_q, or 0 if R0_PROTECT and sel_q=0.
  - While the hold counter is nonzero, decrement it and stay.
  - At zero, go to DONE.
- SWEEP: en = 1<<counter, exactly one cycle per index regardless of STROBE_CYCLES.
  - Counter increments while below 31.
  - At 31, go to DONE. The 5-bit counter must never wrap back to 0.
- DONE: en=0, done=1, busy=1. Next state is IDLE unconditionally.
- req and sweep are ignored while busy=1. They are not queued.
- sel changes after acceptance have no effect; sel_q holds until the next accepted req. sweep does not modify sel_q.
- en never has more than one bit set in any cycle.
- clr, in any state including mid-strobe and mid-sweep:
  - Next cycle: state=IDLE, en=0, sel_q=0, busy=0, done=0, counters=0.
  - No done pulse is produced for an aborted operation.
  - clr overrides a req or sweep presented in the same cycle.

## Timing
- Reset values: en=0, sel_q=0, busy=0, done=0.
- Single select, req accepted at edge t:
  - en valid and busy=1 on cycles t+1 .. t+STROBE_CYCLES.
  - done=1 and en=0 on cycle t+STROBE_CYCLES+1.
  - busy=0 on t+STROBE_CYCLES+2, when a new request can be accepted.
  - Minimum request period is STROBE_CYCLES+2 cycles.
- Sweep accepted at t:
  - en=1<<k on cycle t+1+k, for k=0..31; R0_PROTECT=1 gives k=1..31 on cycles t+1 .. t+31.
  - done on the following cycle: t+33, or t+32 with R0_PROTECT=1.
- Latency from accept to first enable is 1 cycle. No combinational path from inputs to outputs.

## Test plan
- clr held 2 cycles, then req=1, sel=5'd10, STROBE_CYCLES=1 -> en=32'h00000400 for exactly 1 cycle, sel_q=10, then done=1 for 1 cycle, then busy=0.
- STROBE_CYCLES=3, req with sel=31; change sel to 3 and pulse req again while busy -> en=32'h80000000 for 3 cycles; the second req is ignored; one done pulse; sel_q stays 31.
- sweep=1 and req=1 in the same idle cycle, R0_PROTECT=0 -> en walks 32'h1, 32'h2 … 32'h80000000 over 32 consecutive cycles; done on cycle 33; sel_q unchanged.
- R0_PROTECT=1: req with sel=0 -> en stays 0 and done fires at the normal time; sweep -> 31 strobes from 32'h2 to 32'h80000000, with bit 0 never set.
- clr asserted during the 17th sweep cycle -> next cycle en=0, busy=0, done never pulses; a req one cycle later is accepted normally.
- Back-to-back requests for sel=0..31 at the minimum period -> every en vector is one-hot, equals 1<<sel, and yields exactly one done per request.
